// File: rtl/cook_timer.sv
// Microwave cook timer: BCD keypad entry, 1 Hz countdown, door/stop pause handling
// and an end-of-cook beeper held for DONE_TICKS seconds.
module cook_timer #(
  parameter int DONE_TICKS = 3
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       tick_in,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_open,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       magnetron_on,
  output logic       done
);

  localparam int CNT_W = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state_reg, state_next;

  // Digit index 0 is sec_ones, 3 is min_tens.
  logic [3:0] digit_reg   [4];
  logic [3:0] digit_next  [4];
  logic [3:0] shift_digit [4];
  logic [3:0] dec_digit   [4];

  logic [CNT_W-1:0] done_cnt_reg, done_cnt_next;
  logic             magnetron_reg, done_reg;

  // sync_reg[1:0] is the two-flop synchronizer, sync_reg[2] the edge-detect history.
  logic [2:0] sync_reg;
  // valid_reg tracks which sync stages hold real samples since reset, so a level that
  // is already high at reset release is never mistaken for a rising edge.
  logic [2:0] valid_reg;
  logic       tick_pulse;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg  <= '0;
      valid_reg <= '0;
    end else begin
      sync_reg  <= {sync_reg[1:0], tick_in};
      valid_reg <= {valid_reg[1:0], 1'b1};
    end
  end

  assign tick_pulse = valid_reg[2] & sync_reg[1] & ~sync_reg[2];

  for (genvar gi = 0; gi < 4; gi++) begin : g_shift
    if (gi == 0) begin : g_lsd
      assign shift_digit[gi] = key_digit;
    end else begin : g_upper
      assign shift_digit[gi] = digit_reg[gi-1];
    end
  end

  // Countdown with borrow; entered sec_tens above 5 simply count down, only a borrow reloads 5.
  always_comb begin
    dec_digit = digit_reg;
    if (digit_reg[0] != 4'd0) begin
      dec_digit[0] = digit_reg[0] - 4'd1;
    end else begin
      dec_digit[0] = 4'd9;
      if (digit_reg[1] != 4'd0) begin
        dec_digit[1] = digit_reg[1] - 4'd1;
      end else begin
        dec_digit[1] = 4'd5;
        if (digit_reg[2] != 4'd0) begin
          dec_digit[2] = digit_reg[2] - 4'd1;
        end else begin
          dec_digit[2] = 4'd9;
          dec_digit[3] = digit_reg[3] - 4'd1;
        end
      end
    end
  end

  logic digits_zero, dec_zero, key_ok;

  assign digits_zero = (digit_reg[0] == 4'd0) && (digit_reg[1] == 4'd0) &&
                       (digit_reg[2] == 4'd0) && (digit_reg[3] == 4'd0);
  assign dec_zero    = (dec_digit[0] == 4'd0) && (dec_digit[1] == 4'd0) &&
                       (dec_digit[2] == 4'd0) && (dec_digit[3] == 4'd0);
  assign key_ok      = key_valid && (key_digit <= 4'd9);

  always_comb begin
    state_next    = state_reg;
    digit_next    = digit_reg;
    done_cnt_next = done_cnt_reg;
    case (state_reg)
      IDLE, SET: begin
        if (stop_clear) begin
          state_next = IDLE;
          digit_next = '{default: 4'd0};
        end else if (start) begin
          // A start that cannot be honoured still consumes the cycle's key press.
          if (!door_open && !digits_zero) state_next = RUN;
        end else if (key_ok) begin
          digit_next = shift_digit;
          state_next = SET;
        end
      end
      RUN: begin
        if (door_open || stop_clear) begin
          state_next = PAUSE;
        end else if (tick_pulse) begin
          digit_next = dec_digit;
          if (dec_zero) state_next = DONE;
        end
      end
      PAUSE: begin
        if (stop_clear) begin
          state_next = IDLE;
          digit_next = '{default: 4'd0};
        end else if (start && !door_open) begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (stop_clear) begin
          state_next    = IDLE;
          done_cnt_next = '0;
        end else if (tick_pulse) begin
          if (done_cnt_reg == CNT_LAST) begin
            state_next    = IDLE;
            done_cnt_next = '0;
          end else begin
            done_cnt_next = done_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next    = IDLE;
        digit_next    = '{default: 4'd0};
        done_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      digit_reg     <= '{default: 4'd0};
      done_cnt_reg  <= '0;
      magnetron_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      digit_reg     <= digit_next;
      done_cnt_reg  <= done_cnt_next;
      magnetron_reg <= (state_next == RUN);
      done_reg      <= (state_next == DONE);
    end
  end

  assign sec_ones     = digit_reg[0];
  assign sec_tens     = digit_reg[1];
  assign min_ones     = digit_reg[2];
  assign min_tens     = digit_reg[3];
  assign magnetron_on = magnetron_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_cook_timer.sv
// Directed testbench for cook_timer: one task per scenario, inline checks against
// hand-computed display/magnetron/done values.
module tb_cook_timer;

  logic       clock_in = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick_in = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop_clear = 1'b0;
  logic       door_open = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       magnetron_on, done;

  int total = 0;
  int bad = 0;

  logic [15:0] disp;
  assign disp = {min_tens, min_ones, sec_tens, sec_ones};

  cook_timer #(.DONE_TICKS(3)) dut (
    .clock_in    (clock_in),
    .reset_n     (reset_n),
    .tick_in     (tick_in),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .start       (start),
    .stop_clear  (stop_clear),
    .door_open   (door_open),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .magnetron_on(magnetron_on),
    .done        (done)
  );

  always #5 clock_in = ~clock_in;

  task automatic press_key(input logic [3:0] d);
    @(negedge clock_in);
    key_valid = 1'b1;
    key_digit = d;
    @(negedge clock_in);
    key_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock_in);
    start = 1'b1;
    @(negedge clock_in);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clock_in);
    stop_clear = 1'b1;
    @(negedge clock_in);
    stop_clear = 1'b0;
  endtask

  // One full tick_in period; the pulse lands on the 3rd edge after the rise.
  task automatic do_tick();
    @(negedge clock_in);
    tick_in = 1'b1;
    repeat (3) @(negedge clock_in);
    tick_in = 1'b0;
    repeat (3) @(negedge clock_in);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock_in);
    total++; if (disp !== 16'h0000) begin bad++; $display("FAIL reset_disp: got=%h want=%h", disp, 16'h0000); end
    total++; if (magnetron_on !== 1'b0) begin bad++; $display("FAIL reset_mag: got=%b want=0", magnetron_on); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got=%b want=0", done); end
    reset_n = 1'b1;
    @(negedge clock_in);
    $display("reset: disp=%h mag=%b done=%b", disp, magnetron_on, done);
  endtask

  task automatic test_basic();
    press_key(4'd1); press_key(4'd3); press_key(4'd0);
    total++; if (disp !== 16'h0130) begin bad++; $display("FAIL basic_entry: got=%h want=%h", disp, 16'h0130); end
    pulse_start();
    total++; if (magnetron_on !== 1'b1) begin bad++; $display("FAIL basic_mag_on: got=%b want=1", magnetron_on); end
    total++; if (disp !== 16'h0130) begin bad++; $display("FAIL basic_start_disp: got=%h want=%h", disp, 16'h0130); end
    do_tick();
    total++; if (disp !== 16'h0129) begin bad++; $display("FAIL basic_tick1: got=%h want=%h", disp, 16'h0129); end
    for (int i = 0; i < 30; i++) do_tick();
    total++; if (disp !== 16'h0059) begin bad++; $display("FAIL basic_tick31: got=%h want=%h", disp, 16'h0059); end
    total++; if (magnetron_on !== 1'b1) begin bad++; $display("FAIL basic_still_run: got=%b want=1", magnetron_on); end
    pulse_stop();
    total++; if (magnetron_on !== 1'b0) begin bad++; $display("FAIL basic_stop_pause: got=%b want=0", magnetron_on); end
    total++; if (disp !== 16'h0059) begin bad++; $display("FAIL basic_pause_hold: got=%h want=%h", disp, 16'h0059); end
    pulse_stop();
    total++; if (disp !== 16'h0000) begin bad++; $display("FAIL basic_clear: got=%h want=%h", disp, 16'h0000); end
    $display("basic: disp=%h mag=%b", disp, magnetron_on);
  endtask

  task automatic test_done();
    press_key(4'd0); press_key(4'd2);
    total++; if (disp !== 16'h0002) begin bad++; $display("FAIL done_entry: got=%h want=%h", disp, 16'h0002); end
    pulse_start();
    do_tick();
    total++; if (disp !== 16'h0001) begin bad++; $display("FAIL done_tick1: got=%h want=%h", disp, 16'h0001); end
    total++; if (magnetron_on !== 1'b1) begin bad++; $display("FAIL done_tick1_mag: got=%b want=1", magnetron_on); end
    do_tick();
    total++; if (disp !== 16'h0000) begin bad++; $display("FAIL done_zero: got=%h want=%h", disp, 16'h0000); end
    total++; if (magnetron_on !== 1'b0) begin bad++; $display("FAIL done_mag_off: got=%b want=0", magnetron_on); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL done_high: got=%b want=1", done); end
    do_tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL done_hold1: got=%b want=1", done); end
    do_tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL done_hold2: got=%b want=1", done); end
    do_tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_expire: got=%b want=0", done); end
    press_key(4'd7);
    total++; if (disp !== 16'h0007) begin bad++; $display("FAIL done_back_idle: got=%h want=%h", disp, 16'h0007); end
    pulse_stop();
    // Early stop_clear while beeping.
    press_key(4'd1);
    pulse_start();
    do_tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL done_early_high: got=%b want=1", done); end
    pulse_stop();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_early_stop: got=%b want=0", done); end
    press_key(4'd8);
    total++; if (disp !== 16'h0008) begin bad++; $display("FAIL done_early_idle: got=%h want=%h", disp, 16'h0008); end
    pulse_stop();
    $display("done: disp=%h mag=%b done=%b", disp, magnetron_on, done);
  endtask

  task automatic test_pause();
    press_key(4'd4); press_key(4'd5);
    pulse_start();
    total++; if (magnetron_on !== 1'b1) begin bad++; $display("FAIL pause_run: got=%b want=1", magnetron_on); end
    @(negedge clock_in);
    tick_in = 1'b1;
    repeat (2) @(negedge clock_in);
    door_open = 1'b1;
    @(negedge clock_in);
    total++; if (magnetron_on !== 1'b0) begin bad++; $display("FAIL pause_door_mag: got=%b want=0", magnetron_on); end
    total++; if (disp !== 16'h0045) begin bad++; $display("FAIL pause_door_tick: got=%h want=%h", disp, 16'h0045); end
    tick_in = 1'b0;
    repeat (3) @(negedge clock_in);
    do_tick();
    total++; if (disp !== 16'h0045) begin bad++; $display("FAIL pause_hold: got=%h want=%h", disp, 16'h0045); end
    pulse_start();
    total++; if (magnetron_on !== 1'b0) begin bad++; $display("FAIL pause_start_door: got=%b want=0", magnetron_on); end
    @(negedge clock_in);
    door_open = 1'b0;
    pulse_start();
    total++; if (magnetron_on !== 1'b1) begin bad++; $display("FAIL pause_resume: got=%b want=1", magnetron_on); end
    do_tick();
    total++; if (disp !== 16'h0044) begin bad++; $display("FAIL pause_resume_tick: got=%h want=%h", disp, 16'h0044); end
    pulse_stop();
    pulse_stop();
    total++; if (disp !== 16'h0000) begin bad++; $display("FAIL pause_clear: got=%h want=%h", disp, 16'h0000); end
    total++; if (magnetron_on !== 1'b0) begin bad++; $display("FAIL pause_clear_mag: got=%b want=0", magnetron_on); end
    $display("pause: disp=%h mag=%b", disp, magnetron_on);
  endtask

  task automatic test_ignore();
    pulse_start();
    total++; if (magnetron_on !== 1'b0) begin bad++; $display("FAIL ign_zero_start: got=%b want=0", magnetron_on); end
    press_key(4'd3);
    @(negedge clock_in);
    door_open = 1'b1;
    pulse_start();
    total++; if (magnetron_on !== 1'b0) begin bad++; $display("FAIL ign_door_start: got=%b want=0", magnetron_on); end
    door_open = 1'b0;
    press_key(4'hA);
    total++; if (disp !== 16'h0003) begin bad++; $display("FAIL ign_bad_key: got=%h want=%h", disp, 16'h0003); end
    pulse_start();
    press_key(4'd9);
    total++; if (disp !== 16'h0003) begin bad++; $display("FAIL ign_key_in_run: got=%h want=%h", disp, 16'h0003); end
    pulse_stop();
    pulse_stop();
    total++; if (disp !== 16'h0000) begin bad++; $display("FAIL ign_clear: got=%h want=%h", disp, 16'h0000); end
    $display("ignore: disp=%h mag=%b", disp, magnetron_on);
  endtask

  task automatic test_back_to_back();
    press_key(4'd1); press_key(4'd2); press_key(4'd3); press_key(4'd4); press_key(4'd5);
    total++; if (disp !== 16'h2345) begin bad++; $display("FAIL b2b_entry: got=%h want=%h", disp, 16'h2345); end
    @(negedge clock_in);
    start = 1'b1; key_valid = 1'b1; key_digit = 4'd7;
    @(negedge clock_in);
    start = 1'b0; key_valid = 1'b0;
    total++; if (magnetron_on !== 1'b1) begin bad++; $display("FAIL b2b_run: got=%b want=1", magnetron_on); end
    total++; if (disp !== 16'h2345) begin bad++; $display("FAIL b2b_key_dropped: got=%h want=%h", disp, 16'h2345); end
    do_tick();
    total++; if (disp !== 16'h2344) begin bad++; $display("FAIL b2b_tick: got=%h want=%h", disp, 16'h2344); end
    pulse_stop();
    pulse_stop();
    $display("back_to_back: disp=%h mag=%b", disp, magnetron_on);
  endtask

  task automatic test_borrow();
    press_key(4'd1); press_key(4'd0); press_key(4'd0); press_key(4'd0);
    pulse_start();
    do_tick();
    total++; if (disp !== 16'h0959) begin bad++; $display("FAIL borrow_min_tens: got=%h want=%h", disp, 16'h0959); end
    pulse_stop();
    pulse_stop();
    press_key(4'd9); press_key(4'd9);
    total++; if (disp !== 16'h0099) begin bad++; $display("FAIL borrow_99_entry: got=%h want=%h", disp, 16'h0099); end
    pulse_start();
    do_tick();
    total++; if (disp !== 16'h0098) begin bad++; $display("FAIL borrow_99_tick: got=%h want=%h", disp, 16'h0098); end
    pulse_stop();
    pulse_stop();
    press_key(4'd9); press_key(4'd0);
    pulse_start();
    do_tick();
    total++; if (disp !== 16'h0089) begin bad++; $display("FAIL borrow_90_tick: got=%h want=%h", disp, 16'h0089); end
    pulse_stop();
    pulse_stop();
    $display("borrow: disp=%h mag=%b", disp, magnetron_on);
  endtask

  task automatic test_reset_mid_run();
    press_key(4'd5);
    pulse_start();
    @(negedge clock_in);
    tick_in = 1'b1;
    repeat (3) @(negedge clock_in);
    total++; if (disp !== 16'h0004) begin bad++; $display("FAIL rst_run_tick: got=%h want=%h", disp, 16'h0004); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (magnetron_on !== 1'b0) begin bad++; $display("FAIL rst_async_mag: got=%b want=0", magnetron_on); end
    total++; if (disp !== 16'h0000) begin bad++; $display("FAIL rst_async_disp: got=%h want=%h", disp, 16'h0000); end
    @(negedge clock_in);
    reset_n = 1'b1; key_valid = 1'b1; key_digit = 4'd3;
    @(negedge clock_in);
    key_valid = 1'b0; start = 1'b1;
    @(negedge clock_in);
    start = 1'b0;
    total++; if (magnetron_on !== 1'b1) begin bad++; $display("FAIL rst_restart: got=%b want=1", magnetron_on); end
    repeat (8) @(negedge clock_in);
    total++; if (disp !== 16'h0003) begin bad++; $display("FAIL rst_no_spurious: got=%h want=%h", disp, 16'h0003); end
    tick_in = 1'b0;
    repeat (3) @(negedge clock_in);
    do_tick();
    total++; if (disp !== 16'h0002) begin bad++; $display("FAIL rst_next_edge: got=%h want=%h", disp, 16'h0002); end
    pulse_stop();
    pulse_stop();
    $display("reset_mid_run: disp=%h mag=%b", disp, magnetron_on);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_done();
    test_pause();
    test_ignore();
    test_back_to_back();
    test_borrow();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cook_timer.md
COOK_TIMER -- requirements
Module: cook_timer

Interface
REQ-001 SHALL have parameter DONE_TICKS, default 3, giving the number of tick_in rising edges for which done stays high.
REQ-002 SHALL have port clock_in, input, 1, the single system clock; all flops on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port tick_in, input, 1, the 1 Hz divided clock level, asynchronous to clock_in.
REQ-005 SHALL have port key_valid, input, 1, a one-cycle pulse qualifying key_digit.
REQ-006 SHALL have port key_digit, input, 4, the keypad value in BCD.
REQ-007 SHALL have ports start and stop_clear, input, 1 each, one-cycle command pulses.
REQ-008 SHALL have port door_open, input, 1, a synchronous level; 1 means the door is open.
REQ-009 SHALL have ports min_tens, min_ones, sec_tens, sec_ones, output, 4 each, the registered BCD display digits.
REQ-010 SHALL have port magnetron_on, output, 1, registered; 1 only in RUN.
REQ-011 SHALL have port done, output, 1, registered; the end-of-cook beeper.

Function
REQ-012 SHALL pass tick_in through a 2-flop synchronizer and then a rising-edge detector to make a one-cycle tick pulse, 3 clock_in cycles after the tick_in edge.
REQ-013 SHALL implement states IDLE, SET, RUN, PAUSE and DONE.
REQ-014 SHALL, on key_valid with key_digit <= 9 in IDLE or SET, shift the digits left (min_tens<-min_ones<-sec_tens<-sec_ones<-key_digit) and go to SET.
REQ-015 SHALL ignore key_valid when key_digit > 9, and ignore key_valid in RUN, PAUSE and DONE.
REQ-016 SHALL move from IDLE or SET to RUN on start when door_open=0 and the digits are not all zero; otherwise start SHALL be ignored.
REQ-017 SHALL, in RUN on a tick pulse, decrement the time: sec_ones-1; if sec_ones=0 then sec_ones<-9 and sec_tens-1; if sec_tens=0 then sec_tens<-5 and minutes borrow (min_ones-1, or min_ones<-9 with min_tens-1).
REQ-018 SHALL accept entered sec_tens values 6-9 (e.g. 00:99 runs 99 s); only a borrow reloads 5.
REQ-019 SHALL go from RUN to DONE in the same cycle that a decrement produces 00:00.
REQ-020 SHALL, in RUN, go to PAUSE on door_open=1 or stop_clear, holding the digits; no decrement SHALL occur in that cycle even if a tick coincides.
REQ-021 SHALL, in PAUSE, go to RUN on start with door_open=0, and go to IDLE with digits cleared to 0 on stop_clear.
REQ-022 SHALL, in SET, go to IDLE with digits cleared on stop_clear.
REQ-023 SHALL, in DONE, hold done=1 for DONE_TICKS tick pulses, then go to IDLE with done=0; stop_clear in DONE SHALL go to IDLE immediately.
REQ-024 SHALL resolve same-cycle events with priority door_open > stop_clear > start > key_valid; lower-priority events SHALL be dropped.
REQ-025 SHALL make magnetron_on and done follow the state with one cycle of latency (registered from the next state).

Reset
REQ-026 SHALL, while reset_n=0, force IDLE, all digits 0, magnetron_on=0, done=0, the synchronizer flops 0 and the DONE tick counter 0.
REQ-027 SHALL, if reset is asserted mid-RUN, de-assert magnetron_on asynchronously; after release the block SHALL be in IDLE and SHALL NOT produce a spurious tick when tick_in is already high.

Verification
REQ-028 Keys 1,3,0 then start, door closed -> digits 01:30, magnetron_on=1; after 1 tick, 01:29; after 31 ticks total, 00:59.
REQ-029 Entry 00:02, start, 2 ticks -> DONE, magnetron_on=0, done=1 for 3 ticks, then IDLE with done=0.
REQ-030 RUN at 00:45, door_open=1 in the same cycle as a tick -> PAUSE, display stays 00:45; door closed + start -> RUN; stop_clear twice -> IDLE, 00:00.
REQ-031 start with digits 00:00, or with door_open=1 -> stays in IDLE/SET, magnetron_on=0; key 0xA -> display unchanged.
REQ-032 Keys 1,2,3,4,5 -> display 23:45; start and key_valid in the same cycle -> RUN, digits unchanged.
REQ-033 reset_n pulsed low during RUN with tick_in high -> magnetron_on=0 immediately; after release, no decrement until the next tick_in rising edge.
